pipe_mux_n: RTL and testbench

PIPE_MUX_N -- requirements
Module: pipe_mux_n

---
 rtl/pipe_mux_n.sv | 101 ++++++++++
 tb/tb_pipe_mux_n.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mux_n.sv
// pipe_mux_n: registered N:1 select into a main+skid pair; 1 cycle from accept to valid_o.
// Backpressure: ready_o is registered and drops only while both main and skid are full.
module pipe_mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [WIDTH-1:0]        data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    sel_err_o,
  input  logic                    clr_err_i
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid;
  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;
  logic             accept;
  logic             xfer;

  // An index with no matching input yields zero and flags the error.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_i == SEL_W'(k)) begin
        sel_data = data_i[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  assign accept = valid_i && ready_o;
  assign xfer   = valid_o && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= EMPTY;
      valid_o   <= 1'b0;
      data_o    <= '0;
      ready_o   <= 1'b1;
      skid      <= '0;
      sel_err_o <= 1'b0;
    end else begin
      if (accept && !sel_hit) begin
        sel_err_o <= 1'b1;
      end else if (clr_err_i) begin
        sel_err_o <= 1'b0;
      end

      case (state)
        EMPTY: begin
          if (accept) begin
            data_o  <= sel_data;
            valid_o <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && xfer) begin
            data_o <= sel_data;
          end else if (accept) begin
            skid    <= sel_data;
            ready_o <= 1'b0;
            state   <= TWO;
          end else if (xfer) begin
            valid_o <= 1'b0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          // ready_o is low here, so only the drain of main can happen.
          if (xfer) begin
            data_o  <= skid;
            ready_o <= 1'b1;
            state   <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mux_n.sv
// Bench for pipe_mux_n: three configurations share one stimulus stream and are
// checked each cycle against a queue-based reference model.
module tb_pipe_mux_n;

  logic        clk;
  logic        rst;
  logic        vld;
  logic        rdy;
  logic        clr;
  logic [3:0]  s;
  logic [31:0] dw [16];

  logic [127:0] d_a;
  logic [95:0]  d_b;
  logic [127:0] d_c;

  logic        act_vld [3];
  logic        act_rdy [3];
  logic        act_err [3];
  logic [31:0] act_dat [3];
  logic [7:0]  dat_c;

  int n_chk;
  int n_err;
  bit chk_en;

  logic [31:0] mq [3][$];
  logic        m_err [3];
  logic        m_dat0 [3];
  int          m_in [3];
  int          dut_xfer [3];
  int          m_idx;
  logic        m_acc;
  logic        m_xf;
  logic        m_bad;
  logic [31:0] m_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 4; k++) d_a[k*32 +: 32] = dw[k];
  end
  always_comb begin
    for (int k = 0; k < 3; k++) d_b[k*32 +: 32] = dw[k];
  end
  always_comb begin
    for (int k = 0; k < 16; k++) d_c[k*8 +: 8] = dw[k][7:0];
  end
  assign act_dat[2] = {24'h0, dat_c};

  pipe_mux_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_a (
    .clk_i(clk), .rst_i(rst), .sel_i(s[1:0]), .data_i(d_a), .valid_i(vld),
    .ready_o(act_rdy[0]), .data_o(act_dat[0]), .valid_o(act_vld[0]),
    .ready_i(rdy), .sel_err_o(act_err[0]), .clr_err_i(clr));

  pipe_mux_n #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_b (
    .clk_i(clk), .rst_i(rst), .sel_i(s[1:0]), .data_i(d_b), .valid_i(vld),
    .ready_o(act_rdy[1]), .data_o(act_dat[1]), .valid_o(act_vld[1]),
    .ready_i(rdy), .sel_err_o(act_err[1]), .clr_err_i(clr));

  pipe_mux_n #(.WIDTH(8), .NUM_IN(16), .SEL_W(4)) u_c (
    .clk_i(clk), .rst_i(rst), .sel_i(s), .data_i(d_c), .valid_i(vld),
    .ready_o(act_rdy[2]), .data_o(dat_c), .valid_o(act_vld[2]),
    .ready_i(rdy), .sel_err_o(act_err[2]), .clr_err_i(clr));

  function automatic int num_of(input int i);
    case (i)
      0:       return 4;
      1:       return 3;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int i);
    return (i == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered queue of at most two items per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mq[i].delete();
        m_err[i]  = 1'b0;
        m_dat0[i] = 1'b1;
        m_in[i]   = 0;
      end else begin
        m_acc = vld && (mq[i].size() < 2);
        m_xf  = (mq[i].size() > 0) && rdy;
        m_idx = (i == 2) ? int'(s) : int'(s[1:0]);
        m_bad = (m_idx >= num_of(i));
        m_v   = m_bad ? 32'h0 : (dw[m_idx] & mask_of(i));
        if (m_xf) void'(mq[i].pop_front());
        if (m_acc) begin
          mq[i].push_back(m_v);
          m_in[i]++;
          m_dat0[i] = 1'b0;
        end
        if (m_acc && m_bad) m_err[i] = 1'b1;
        else if (clr) m_err[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) dut_xfer[i] = 0;
      else if (act_vld[i] && rdy) dut_xfer[i]++;
      if (chk_en) begin
        chk($sformatf("i%0d_valid", i), 32'(act_vld[i]), 32'(mq[i].size() > 0));
        chk($sformatf("i%0d_ready", i), 32'(act_rdy[i]), 32'(mq[i].size() < 2));
        chk($sformatf("i%0d_sel_err", i), 32'(act_err[i]), 32'(m_err[i]));
        if (mq[i].size() > 0)
          chk($sformatf("i%0d_data", i), act_dat[i], mq[i][0]);
        else if (m_dat0[i])
          chk($sformatf("i%0d_data_rst", i), act_dat[i], 32'h0);
      end
    end
  end

  initial begin
    logic [31:0] v;
    n_chk  = 0;
    n_err  = 0;
    chk_en = 1'b0;
    rst = 1'b1; vld = 1'b0; rdy = 1'b0; clr = 1'b0; s = 4'd0;
    for (int k = 0; k < 16; k++) dw[k] = 32'hA0A0_0000 + 32'(k);

    // Reset state
    step();
    step();
    chk("rst_valid", 32'(act_vld[0]), 32'h0);
    chk("rst_data", act_dat[0], 32'h0);
    chk("rst_ready", 32'(act_rdy[0]), 32'h1);
    chk("rst_err", 32'(act_err[0]), 32'h0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Single item through an idle block
    s = 4'd2; dw[2] = 32'hDEAD_BEEF; vld = 1'b1; rdy = 1'b1;
    step();
    chk("single_valid", 32'(act_vld[0]), 32'h1);
    chk("single_data", act_dat[0], 32'hDEAD_BEEF);
    vld = 1'b0;
    step();
    chk("single_drained", 32'(act_vld[0]), 32'h0);

    // Stall: A in main, B in skid, C held upstream
    rdy = 1'b0; vld = 1'b1; s = 4'd1; dw[1] = 32'hAAAA_0001;
    step();
    chk("stall_a_data", act_dat[0], 32'hAAAA_0001);
    chk("stall_a_ready", 32'(act_rdy[0]), 32'h1);
    dw[1] = 32'hBBBB_0002;
    step();
    chk("stall_two_ready", 32'(act_rdy[0]), 32'h0);
    chk("stall_two_data", act_dat[0], 32'hAAAA_0001);
    dw[1] = 32'hCCCC_0003;
    step();
    chk("stall_hold_data", act_dat[0], 32'hAAAA_0001);
    step();
    chk("stall_hold_ready", 32'(act_rdy[0]), 32'h0);
    rdy = 1'b1;
    step();
    chk("drain_b", act_dat[0], 32'hBBBB_0002);
    step();
    chk("drain_c", act_dat[0], 32'hCCCC_0003);
    vld = 1'b0;
    step();
    chk("drain_empty", 32'(act_vld[0]), 32'h0);

    // Full-rate streaming
    rdy = 1'b1; vld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s = 4'(i % 4);
      v = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      dw[i % 4] = v;
      step();
      chk("stream_data", act_dat[0], v);
      chk("stream_ready", 32'(act_rdy[0]), 32'h1);
    end
    vld = 1'b0;
    step();

    // Out-of-range select on the 3-input instance
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("err_cleared", 32'(act_err[1]), 32'h0);
    vld = 1'b1; s = 4'd3; dw[3] = 32'h1234_5678;
    step();
    chk("err_zero_data", act_dat[1], 32'h0);
    chk("err_set", 32'(act_err[1]), 32'h1);
    chk("err_a_in_range", act_dat[0], 32'h1234_5678);
    vld = 1'b0;
    step();
    chk("err_sticky", 32'(act_err[1]), 32'h1);
    vld = 1'b1; clr = 1'b1;
    step();
    chk("err_set_wins", 32'(act_err[1]), 32'h1);
    vld = 1'b0;
    step();
    chk("err_clr", 32'(act_err[1]), 32'h0);
    clr = 1'b0;

    // Reset while holding two items
    rdy = 1'b0; vld = 1'b1; s = 4'd0; dw[0] = 32'h5555_0001;
    step();
    dw[0] = 32'h5555_0002;
    step();
    chk("two_ready", 32'(act_rdy[0]), 32'h0);
    rst = 1'b1; rdy = 1'b1;
    step();
    chk("midrst_valid", 32'(act_vld[0]), 32'h0);
    chk("midrst_data", act_dat[0], 32'h0);
    chk("midrst_ready", 32'(act_rdy[0]), 32'h1);
    rst = 1'b0; vld = 1'b0;
    repeat (3) step();
    chk("midrst_no_stale", 32'(act_vld[0]), 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      vld = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      s   = 4'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) dw[k] = $urandom;
      step();
    end
    vld = 1'b0; rdy = 1'b1; clr = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 3; i++)
      chk($sformatf("i%0d_stream_count", i), 32'(dut_xfer[i]), 32'(m_in[i]));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
